posit_encoder: RTL

- Pipelined posit(n,es) encoder; the transmit-side counterpart of the posit decoder.
- Takes decoded fields (sign, signed regime k, exponent, fraction, zero/NaR flags) and produces an n-bit posit word.
- Rounds to nearest-even and saturates to the largest/smallest positive value instead of rounding to zero or NaR.
- Sits after the arithmetic datapath.
- 3-stage pipeline with valid/ready handshake on both sides.

---
 rtl/posit_pkg.sv | 42 ++++
 rtl/posit_encoder_if.sv | 27 ++
 rtl/posit_round.sv | 46 ++++
 rtl/posit_encoder.sv | 119 +++++++++++
 4 files changed

// File: rtl/posit_pkg.sv
// Shared constants, derived widths and stage payload types for the posit(16,1) encoder.
package posit_pkg;

  localparam int unsigned N    = 16;
  localparam int unsigned ES   = 1;
  localparam int unsigned RS   = 5;
  localparam int unsigned FS   = N - ES - 3;
  localparam int unsigned NB   = N - 1;
  localparam int unsigned XW   = 2 * N;
  localparam int unsigned EFW  = ES + FS;
  localparam int unsigned PADW = XW - 1 - EFW;
  localparam int unsigned LW   = $clog2(N) + 1;

  localparam int KMAX = int'(N) - 2;
  localparam int KMIN = 1 - int'(N);

  localparam logic [N-1:0] NAR_WORD  = {1'b1, {(N-1){1'b0}}};
  localparam logic [N-1:0] ZERO_WORD = '0;

  // Stage 1 -> stage 2: classified fields with clamped regime run length.
  typedef struct packed {
    logic           sign;
    logic           zero;
    logic           nar;
    logic           sat_hi;
    logic           r0;
    logic [LW-1:0]  len;
    logic [EFW-1:0] ef;
  } s1_t;

  // Stage 2 -> stage 3: truncated body plus rounding information.
  typedef struct packed {
    logic          sign;
    logic          zero;
    logic          nar;
    logic          sat_hi;
    logic [NB-1:0] body;
    logic          guard;
    logic          sticky;
  } s2_t;

endpackage

// File: rtl/posit_encoder_if.sv
// Input field bus and output posit bus of the encoder, with both handshakes.
interface posit_encoder_if;
  import posit_pkg::*;

  logic          in_valid;
  logic          in_ready;
  logic          sign;
  logic [RS-1:0] regi;
  logic [ES-1:0] expo;
  logic [FS-1:0] frac;
  logic          allzero;
  logic          allone;
  logic          out_valid;
  logic          out_ready;
  logic [N-1:0]  out_posit;

  modport master (
    output in_valid, sign, regi, expo, frac, allzero, allone, out_ready,
    input  in_ready, out_valid, out_posit
  );

  modport slave (
    input  in_valid, sign, regi, expo, frac, allzero, allone, out_ready,
    output in_ready, out_valid, out_posit
  );

endinterface

// File: rtl/posit_round.sv
// Round-to-nearest-even on the assembled body with maxpos/minpos saturation,
// sign application and special-value override.
module posit_round
  import posit_pkg::*;
(
  input  logic          sign,
  input  logic          zero,
  input  logic          nar,
  input  logic          sat_hi,
  input  logic [NB-1:0] body,
  input  logic          guard,
  input  logic          sticky,
  output logic [N-1:0]  posit_c
);

  logic          round_up_c;
  logic [NB-1:0] mag_c;
  logic [N-1:0]  word_c;

  always_comb begin
    round_up_c = guard && (sticky || body[0]);
    mag_c      = body;
    // Never round to zero and never carry past maxpos into the NaR pattern.
    if (sat_hi) begin
      mag_c = '1;
    end else if (body == '0) begin
      mag_c = NB'(1);
    end else if (round_up_c && (body != '1)) begin
      mag_c = body + NB'(1);
    end

    word_c = {1'b0, mag_c};
    if (sign) begin
      word_c = (~word_c) + N'(1);
    end

    posit_c = word_c;
    if (zero) begin
      posit_c = ZERO_WORD;
    end
    if (nar) begin
      posit_c = NAR_WORD;
    end
  end

endmodule

// File: rtl/posit_encoder.sv
// Three-stage posit(16,1) encoder: classify/clamp, assemble, round. All stages
// share one advance signal so the pipeline stalls as a unit.
module posit_encoder
  import posit_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  posit_encoder_if.slave  bus
);

  logic advance_c;

  logic s1_valid_q, s1_valid_d;
  logic s2_valid_q, s2_valid_d;
  logic out_valid_q, out_valid_d;

  s1_t s1_q, s1_d, s1_new_c;
  s2_t s2_q, s2_d, s2_new_c;

  logic [N-1:0] out_posit_q, out_posit_d;
  logic [N-1:0] rounded_c;

  logic signed [RS-1:0] k_c;
  logic signed [RS-1:0] kc_c;

  logic [XW-1:0] tail_c;
  logic [XW-1:0] ext_c;
  logic [LW-1:0] sh_c;

  assign advance_c     = !out_valid_q || bus.out_ready;
  assign bus.in_ready  = advance_c;
  assign bus.out_valid = out_valid_q;
  assign bus.out_posit = out_posit_q;

  assign k_c = bus.regi;

  // Stage 1: clamp k so the regime never wraps, derive run length and run bit.
  always_comb begin
    kc_c = k_c;
    if (int'(k_c) > KMAX) begin
      kc_c = RS'(KMAX);
    end else if (int'(k_c) < KMIN) begin
      kc_c = RS'(KMIN);
    end

    s1_new_c        = '0;
    s1_new_c.sign   = bus.sign;
    s1_new_c.zero   = bus.allzero;
    s1_new_c.nar    = bus.allone;
    s1_new_c.sat_hi = (int'(k_c) >= KMAX);
    s1_new_c.r0     = !kc_c[RS-1];
    s1_new_c.len    = s1_new_c.r0 ? LW'(int'(kc_c) + 2) : LW'(1 - int'(kc_c));
    s1_new_c.ef     = {bus.expo, bus.frac};
  end

  // Stage 2: shift the terminator+fields right under a fill of len-1 run bits.
  always_comb begin
    tail_c = {~s1_q.r0, s1_q.ef, {PADW{1'b0}}};
    sh_c   = s1_q.len - LW'(1);
    ext_c  = s1_q.r0 ? ~((~tail_c) >> sh_c) : (tail_c >> sh_c);

    s2_new_c        = '0;
    s2_new_c.sign   = s1_q.sign;
    s2_new_c.zero   = s1_q.zero;
    s2_new_c.nar    = s1_q.nar;
    s2_new_c.sat_hi = s1_q.sat_hi;
    s2_new_c.body   = ext_c[XW-1 -: NB];
    s2_new_c.guard  = ext_c[XW-1-NB];
    s2_new_c.sticky = |ext_c[XW-2-NB:0];
  end

  posit_round u_round (
    .sign    (s2_q.sign),
    .zero    (s2_q.zero),
    .nar     (s2_q.nar),
    .sat_hi  (s2_q.sat_hi),
    .body    (s2_q.body),
    .guard   (s2_q.guard),
    .sticky  (s2_q.sticky),
    .posit_c (rounded_c)
  );

  // Next-state: every stage loads from its predecessor only on advance.
  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_d        = s1_q;
    s2_valid_d  = s2_valid_q;
    s2_d        = s2_q;
    out_valid_d = out_valid_q;
    out_posit_d = out_posit_q;
    if (advance_c) begin
      s1_valid_d  = bus.in_valid;
      s1_d        = s1_new_c;
      s2_valid_d  = s1_valid_q;
      s2_d        = s2_new_c;
      out_valid_d = s2_valid_q;
      out_posit_d = rounded_c;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_q        <= '0;
      s2_valid_q  <= 1'b0;
      s2_q        <= '0;
      out_valid_q <= 1'b0;
      out_posit_q <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_q        <= s1_d;
      s2_valid_q  <= s2_valid_d;
      s2_q        <= s2_d;
      out_valid_q <= out_valid_d;
      out_posit_q <= out_posit_d;
    end
  end

endmodule
